// File: rtl/dg_pc_pkg.sv
// Shared types and helpers for the DG-series program-counter unit:
// opcode encoding, default feedback taps and the in-page sequence function.
package dg_pc_pkg;

  localparam int unsigned LFSR_MAX_W = 32;
  localparam logic [5:0] DG_DEFAULT_TAPS = 6'b000011;

  typedef enum logic [2:0] {
    OP_SEQ   = 3'd0,
    OP_JMP   = 3'd1,
    OP_CALL  = 3'd2,
    OP_RET   = 3'd3,
    OP_LJMP  = 3'd4,
    OP_LCALL = 3'd5
  } op_e;

  // Shift right, feeding XNOR of the tapped bits into bit w-1; all-ones maps to itself.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_nxt(
    input logic [LFSR_MAX_W-1:0] pl,
    input logic [LFSR_MAX_W-1:0] taps,
    input int unsigned           w
  );
    logic fb;
    fb = ~(^(pl & taps));
    return (pl >> 1) | ({{(LFSR_MAX_W-1){1'b0}}, fb} << (w - 32'd1));
  endfunction

endpackage

// File: rtl/dg_pc_unit_if.sv
// Decoder-side bundle of the program-counter unit: step/op/targets in,
// ROM address and stack status out.
interface dg_pc_unit_if #(
  parameter int unsigned PL_W = 6,
  parameter int unsigned PU_W = 4,
  parameter int unsigned CW   = 3
);

  logic            step;
  logic [2:0]      op;
  logic [PL_W-1:0] tgt_pl;
  logic [PU_W-1:0] tgt_pu;
  logic            clr_flags;
  logic [PU_W+PL_W-1:0] pc;
  logic [CW-1:0]   depth;
  logic            ovf;
  logic            unf;

  modport master (
    output step, op, tgt_pl, tgt_pu, clr_flags,
    input  pc, depth, ovf, unf
  );

  modport slave (
    input  step, op, tgt_pl, tgt_pu, clr_flags,
    output pc, depth, ovf, unf
  );

endinterface

// File: rtl/dg_ret_stack.sv
// Return-address stack: entry 0 is the top, pushes shift down and drop the
// oldest entry when full, pops shift up and zero-fill the bottom slot.
module dg_ret_stack #(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned W     = 10,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  top_o,
  output logic [CW-1:0] depth_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [CW-1:0] depth_q;
  logic [CW-1:0] depth_d;

  assign full_o  = (depth_q == CW'(DEPTH));
  assign empty_o = (depth_q == {CW{1'b0}});
  assign top_o   = mem_q[0];
  assign depth_o = depth_q;

  // Next stack contents and occupancy for one push or one pop.
  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    if (push_i) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem_d[i] = mem_q[i-1];
      end
      mem_d[0] = wdata_i;
      if (!full_o) begin
        depth_d = depth_q + CW'(1);
      end else begin
        depth_d = depth_q;
      end
    end else if (pop_i) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      mem_d[DEPTH-1] = {W{1'b0}};
      if (!empty_o) begin
        depth_d = depth_q - CW'(1);
      end else begin
        depth_d = depth_q;
      end
    end else begin
      mem_d   = mem_q;
      depth_d = depth_q;
    end
  end

  // Stack state register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
      depth_q <= {CW{1'b0}};
    end else begin
      mem_q   <= mem_d;
      depth_q <= depth_d;
    end
  end

endmodule

// File: rtl/dg_pc_unit.sv
// Program counter for DG-series cores: polynomial in-page counter PL, page
// register PU, op decode, return stack and sticky overflow/underflow flags.
module dg_pc_unit
  import dg_pc_pkg::*;
#(
  parameter int unsigned     PL_W  = 6,
  parameter int unsigned     PU_W  = 4,
  parameter logic [PL_W-1:0] TAPS  = DG_DEFAULT_TAPS,
  parameter int unsigned     DEPTH = 5,
  parameter int unsigned     CW    = $clog2(DEPTH + 1)
) (
  input logic          clk,
  input logic          rst_n,
  dg_pc_unit_if.slave  bus
);

  localparam int unsigned W = PU_W + PL_W;

  logic [PL_W-1:0] pl_q;
  logic [PL_W-1:0] pl_d;
  logic [PL_W-1:0] pl_seq_s;
  logic [PU_W-1:0] pu_q;
  logic [PU_W-1:0] pu_d;
  logic            ovf_q;
  logic            ovf_d;
  logic            unf_q;
  logic            unf_d;
  logic            push_s;
  logic            pop_s;
  logic            full_s;
  logic            empty_s;
  logic [W-1:0]    top_s;
  logic [W-1:0]    ret_addr_s;
  logic [CW-1:0]   depth_s;

  assign pl_seq_s   = PL_W'(lfsr_nxt(LFSR_MAX_W'(pl_q), LFSR_MAX_W'(TAPS), PL_W));
  assign ret_addr_s = {pu_q, pl_seq_s};

  dg_ret_stack #(
    .DEPTH (DEPTH),
    .W     (W),
    .CW    (CW)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (ret_addr_s),
    .top_o   (top_s),
    .depth_o (depth_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Op decode: next {PU,PL} and the single stack action for this step.
  always_comb begin
    pl_d   = pl_q;
    pu_d   = pu_q;
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (bus.step) begin
      case (bus.op)
        OP_JMP: begin
          pl_d = bus.tgt_pl;
        end
        OP_LJMP: begin
          pu_d = bus.tgt_pu;
          pl_d = bus.tgt_pl;
        end
        OP_CALL: begin
          push_s = 1'b1;
          pu_d   = {PU_W{1'b1}};
          pl_d   = bus.tgt_pl;
        end
        OP_LCALL: begin
          push_s = 1'b1;
          pu_d   = bus.tgt_pu;
          pl_d   = bus.tgt_pl;
        end
        OP_RET: begin
          pop_s = 1'b1;
          if (empty_s) begin
            pu_d = {PU_W{1'b0}};
            pl_d = {PL_W{1'b0}};
          end else begin
            {pu_d, pl_d} = top_s;
          end
        end
        default: begin
          pl_d = pl_seq_s;
        end
      endcase
    end else begin
      pl_d = pl_q;
      pu_d = pu_q;
    end
  end

  // Sticky flags: a new event in this cycle beats a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (push_s && full_s) begin
      ovf_d = 1'b1;
    end else if (bus.clr_flags) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (pop_s && empty_s) begin
      unf_d = 1'b1;
    end else if (bus.clr_flags) begin
      unf_d = 1'b0;
    end else begin
      unf_d = unf_q;
    end
  end

  // PC and flag registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pl_q  <= {PL_W{1'b0}};
      pu_q  <= {PU_W{1'b0}};
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pl_q  <= pl_d;
      pu_q  <= pu_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.pc    = {pu_q, pl_q};
  assign bus.depth = depth_s;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;

endmodule

// File: tb/tb_dg_pc_unit.sv
// Directed bench for dg_pc_unit: a queue-based reference model is checked
// every cycle, plus hand-computed pc/depth/flag values at key points.
module tb_dg_pc_unit;
  import dg_pc_pkg::*;

  localparam int PL_W  = 6;
  localparam int PU_W  = 4;
  localparam int DEPTH = 5;
  localparam int CW    = 3;
  localparam logic [5:0] TB_TAPS = 6'b000011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  dg_pc_unit_if #(.PL_W(PL_W), .PU_W(PU_W), .CW(CW)) bus ();

  dg_pc_unit #(
    .PL_W  (PL_W),
    .PU_W  (PU_W),
    .TAPS  (TB_TAPS),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: pc as an integer page*64+offset, stack as a queue.
  int m_pc;
  int m_stk[$];
  bit m_ovf, m_unf;
  int mp_pl, mp_pu, mp_ret;
  bit mp_set_ovf, mp_set_unf;

  function automatic int seq_nxt(input int pl);
    int ones;
    ones = 0;
    for (int i = 0; i < 6; i++) begin
      if ((((pl >> i) & 1) == 1) && TB_TAPS[i]) ones++;
    end
    return (pl >> 1) + (((ones % 2) == 0) ? 32 : 0);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = 0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      mp_set_ovf = 1'b0;
      mp_set_unf = 1'b0;
      mp_pl = m_pc % 64;
      mp_pu = m_pc / 64;
      if (bus.step) begin
        case (int'(bus.op))
          1: m_pc = mp_pu * 64 + int'(bus.tgt_pl);
          2, 5: begin
            mp_ret = mp_pu * 64 + seq_nxt(mp_pl);
            if (m_stk.size() == DEPTH) begin
              void'(m_stk.pop_back());
              mp_set_ovf = 1'b1;
            end
            m_stk.push_front(mp_ret);
            m_pc = ((int'(bus.op) == 2) ? 15 : int'(bus.tgt_pu)) * 64 + int'(bus.tgt_pl);
          end
          3: begin
            if (m_stk.size() == 0) begin
              m_pc = 0;
              mp_set_unf = 1'b1;
            end else begin
              m_pc = m_stk.pop_front();
            end
          end
          4: m_pc = int'(bus.tgt_pu) * 64 + int'(bus.tgt_pl);
          default: m_pc = mp_pu * 64 + seq_nxt(mp_pl);
        endcase
      end
      if (bus.clr_flags) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (mp_set_ovf) m_ovf = 1'b1;
      if (mp_set_unf) m_unf = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pc", 32'(bus.pc), 32'(m_pc));
      check("model_depth", 32'(bus.depth), 32'(m_stk.size()));
      check("model_ovf", 32'(bus.ovf), 32'(m_ovf));
      check("model_unf", 32'(bus.unf), 32'(m_unf));
    end
  end

  task automatic do_step(input logic [2:0] op, input logic [5:0] tpl, input logic [3:0] tpu,
                         input logic clr);
    bus.step      = 1'b1;
    bus.op        = op;
    bus.tgt_pl    = tpl;
    bus.tgt_pu    = tpu;
    bus.clr_flags = clr;
    @(posedge clk);
    #1;
    bus.step      = 1'b0;
    bus.clr_flags = 1'b0;
    bus.op        = 3'd0;
  endtask

  task automatic clr_only();
    bus.clr_flags = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_flags = 1'b0;
  endtask

  bit seen[64];
  int distinct;
  bit pu_zero;
  logic [9:0] exp_ret[5];

  initial begin
    bus.step      = 1'b0;
    bus.op        = 3'd0;
    bus.tgt_pl    = 6'd0;
    bus.tgt_pu    = 4'd0;
    bus.clr_flags = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    check("reset_pc", 32'(bus.pc), 32'h000);
    check("reset_depth", 32'(bus.depth), 32'd0);
    check("reset_flags", {30'd0, bus.ovf, bus.unf}, 32'd0);

    distinct = 0;
    pu_zero  = 1'b1;
    for (int i = 1; i <= 63; i++) begin
      do_step(OP_SEQ, 6'd0, 4'd0, 1'b0);
      if (!seen[bus.pc[5:0]]) begin
        seen[bus.pc[5:0]] = 1'b1;
        distinct++;
      end
      if (bus.pc[9:6] != 4'd0) pu_zero = 1'b0;
      if (i == 1) check("seq_step1", 32'(bus.pc), 32'h020);
      if (i == 2) check("seq_step2", 32'(bus.pc), 32'h030);
      if (i == 3) check("seq_step3", 32'(bus.pc), 32'h038);
    end
    check("seq_distinct", 32'(distinct), 32'd63);
    check("seq_wrap", 32'(bus.pc), 32'h000);
    check("seq_pu_zero", 32'(pu_zero), 32'd1);

    do_step(OP_LJMP, 6'h02, 4'd2, 1'b0);
    check("ljmp_082", 32'(bus.pc), 32'h082);
    do_step(OP_JMP, 6'h15, 4'd9, 1'b0);
    check("jmp_095", 32'(bus.pc), 32'h095);
    do_step(OP_LJMP, 6'h3E, 4'd7, 1'b0);
    check("ljmp_1fe", 32'(bus.pc), 32'h1FE);

    do_step(OP_LJMP, 6'h05, 4'd2, 1'b0);
    do_step(OP_CALL, 6'h0A, 4'd0, 1'b0);
    check("call_pc", 32'(bus.pc), 32'h3CA);
    check("call_depth", 32'(bus.depth), 32'd1);
    do_step(OP_RET, 6'd0, 4'd0, 1'b0);
    check("ret_pc", 32'(bus.pc), 32'h082);
    check("ret_depth", 32'(bus.depth), 32'd0);
    check("ret_flags", {30'd0, bus.ovf, bus.unf}, 32'd0);

    // Six calls from {1,0x00} with targets 1..6; return of call 1 (0x060) is dropped.
    do_step(OP_LJMP, 6'h00, 4'd1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      do_step(OP_CALL, 6'(k), 4'd0, 1'b0);
    end
    check("ovf_pc", 32'(bus.pc), 32'h3C6);
    check("ovf_flag", 32'(bus.ovf), 32'd1);
    check("ovf_depth", 32'(bus.depth), 32'd5);
    exp_ret[0] = 10'h3C2;
    exp_ret[1] = 10'h3E2;
    exp_ret[2] = 10'h3E1;
    exp_ret[3] = 10'h3C1;
    exp_ret[4] = 10'h3C0;
    for (int k = 0; k < 5; k++) begin
      do_step(OP_RET, 6'd0, 4'd0, 1'b0);
      check($sformatf("ret_chain%0d", k), 32'(bus.pc), 32'(exp_ret[k]));
    end
    check("chain_depth0", 32'(bus.depth), 32'd0);
    do_step(OP_RET, 6'd0, 4'd0, 1'b0);
    check("unf_pc", 32'(bus.pc), 32'h000);
    check("unf_flag", 32'(bus.unf), 32'd1);
    check("unf_ovf_kept", 32'(bus.ovf), 32'd1);
    clr_only();
    check("clr_flags", {30'd0, bus.ovf, bus.unf}, 32'd0);

    do_step(OP_JMP, 6'h3F, 4'd0, 1'b0);
    check("lock_jmp", 32'(bus.pc), 32'h03F);
    for (int k = 0; k < 3; k++) begin
      do_step(OP_SEQ, 6'd0, 4'd0, 1'b0);
      check($sformatf("lock_seq%0d", k), 32'(bus.pc), 32'h03F);
    end

    do_step(OP_RET, 6'd0, 4'd0, 1'b1);
    check("unf_beats_clr", 32'(bus.unf), 32'd1);
    check("unf_beats_clr_pc", 32'(bus.pc), 32'h000);
    clr_only();
    check("clr_after", {30'd0, bus.ovf, bus.unf}, 32'd0);

    for (int k = 1; k <= 3; k++) begin
      do_step(OP_CALL, 6'(k), 4'd0, 1'b0);
    end
    check("pre_rst_depth", 32'(bus.depth), 32'd3);
    bus.step   = 1'b1;
    bus.op     = OP_CALL;
    bus.tgt_pl = 6'h11;
    rst_n      = 1'b0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    bus.step = 1'b0;
    bus.op   = 3'd0;
    check("rst_pc", 32'(bus.pc), 32'h000);
    check("rst_depth", 32'(bus.depth), 32'd0);
    check("rst_flags", {30'd0, bus.ovf, bus.unf}, 32'd0);
    do_step(OP_RET, 6'd0, 4'd0, 1'b0);
    check("rst_stack_empty", 32'(bus.unf), 32'd1);

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
